renkon_ctrl_wb: RTL
===================

# renkon_ctrl_wb

Write-back stage directly downstream of the pooling control/datapath in the renkon pipeline. Consumes the pooled control bus (start/valid/stop) plus CORE parallel pooled words, serializes them into one-word-per-cycle writes to the output feature memory, and computes channel-major addresses. Provides two-slot ping-pong capture so back-to-back valids are absorbed, and signals layer completion with a one-cycle ack.

## Interface
Parameters:
- CORE, 8, parallel output channels per valid beat
- DWIDTH, 16, data word width
- MEMWIDTH, 12, output memory address width

Ports:
- clk  in  1  clock
- xrst  in  1  reset; asynchronous, active-low
- in_ctrl  ctrl_bus.slave  -  start/valid/stop/delay from pooling stage
- in_data  in  CORE x DWIDTH  pooled words, valid when in_ctrl.valid
- _out_base  in  MEMWIDTH  base address of channel 0, latched on start
- _map_size  in  MEMWIDTH  words per output map (pixels per channel), latched on start
- mem_we  out  1  output memory write enable
- mem_addr  out  MEMWIDTH  write address
- mem_wdata  out  DWIDTH  write data
- wb_busy  out  1  high in S_ACTIVE or S_DRAIN
- wb_ack  out  1  one-cycle pulse, layer fully written
- wb_overrun  out  1  sticky: a valid beat was dropped

## Operation
- States: S_IDLE, S_ACTIVE, S_DRAIN.
- S_IDLE: on in_ctrl.start, latch _out_base/_map_size, clear pix counter, clear wb_overrun, go S_ACTIVE. start outside S_IDLE ignored.
- S_ACTIVE: each in_ctrl.valid captures in_data into the free slot (slot 0 then 1, alternating write pointer). in_ctrl.stop -> S_DRAIN; valid and stop on same cycle: beat captured.
- Valid with both slots full: beat dropped, wb_overrun set, slot contents unchanged.
- Serializer: when a slot is full and serializer idle, it drains that slot (read pointer order) over CORE consecutive cycles, channel c = 0..CORE-1; address = base + c*map_size + pix, generated by incremental add (no multiplier), modulo 2^MEMWIDTH. After word CORE-1: slot freed, pix += 1, next full slot starts next cycle with no bubble.
- S_DRAIN: valids ignored. When both slots empty and serializer idle: wb_ack pulses one cycle, -> S_IDLE.
- Slot freed and recaptured on the same cycle is legal (free-then-capture).

## Timing
- Reset (async assert, any state): state S_IDLE; mem_we 0, mem_addr 0, mem_wdata 0, wb_busy 0, wb_ack 0, wb_overrun 0; slots empty, pointers and counters 0. Release is synchronous to clk.
- All outputs registered. Valid sampled at edge E -> mem_we high for cycles after edges E+1 .. E+CORE (c = 0..CORE-1) when serializer idle.
- Sustained throughput: one beat per CORE cycles without overrun; a burst of 2 beats closer together is absorbed.
- wb_ack asserted the cycle after the last write's cycle once stop was seen; wb_busy falls with wb_ack's cycle.
- wb_overrun holds until next accepted start or reset.
- in_ctrl.delay not used internally.

## Test plan
- Reset mid-layer: assert xrst low during S_ACTIVE with mem_we high -> all outputs 0 immediately, next start behaves as fresh layer.
- Single beat, CORE=8, base=0x100, map_size=4, data c*1+1 -> 8 writes at 0x100,0x104,...,0x11C with data 1..8, then stop -> wb_ack one cycle, wb_busy 0.
- Two beats one cycle apart -> 16 contiguous mem_we cycles, second beat addresses 0x101,0x105,...; no overrun.
- Three beats on consecutive cycles -> third dropped, wb_overrun=1, exactly 16 writes; new start clears wb_overrun.
- Address wrap: MEMWIDTH=12, base=0xFFE, map_size=1 -> addresses 0xFFE,0xFFF,0x000,...
- valid and stop same cycle -> beat written, then wb_ack; start during S_DRAIN ignored (base unchanged).

Source files
------------

// File: rtl/renkon_ctrl_wb_if.sv
// Control bus between renkon pipeline stages: layer start/stop framing plus per-beat valid.
interface ctrl_bus;
    logic start;
    logic valid;
    logic stop;
    logic delay;

    modport master (output start, valid, stop, delay);
    modport slave  (input  start, valid, stop, delay);
endinterface

// File: rtl/renkon_ctrl_wb.sv
// Write-back stage: captures CORE-wide pooled beats into two ping-pong slots and
// serializes them one word per cycle to channel-major output memory addresses.
module renkon_ctrl_wb #(
    parameter int CORE     = 8,
    parameter int DWIDTH   = 16,
    parameter int MEMWIDTH = 12
) (
    input  logic                           clk,
    input  logic                           xrst,
    ctrl_bus.slave                         in_ctrl,
    input  logic [CORE-1:0][DWIDTH-1:0]    in_data,
    input  logic [MEMWIDTH-1:0]            _out_base,
    input  logic [MEMWIDTH-1:0]            _map_size,
    output logic                           mem_we,
    output logic [MEMWIDTH-1:0]            mem_addr,
    output logic [DWIDTH-1:0]              mem_wdata,
    output logic                           wb_busy,
    output logic                           wb_ack,
    output logic                           wb_overrun
);

    // Channel counter width; CORE is expected to be at least 2.
    localparam int CW = (CORE > 1) ? $clog2(CORE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN
    } state_t;

    state_t state, state_nx;

    logic [1:0][CORE-1:0][DWIDTH-1:0] slot_data;
    logic [1:0]                       slot_full;
    logic                             wr_ptr;
    logic                             rd_ptr;

    logic                             ser_act;
    logic [CW-1:0]                    ch;
    logic [MEMWIDTH-1:0]              run_addr;
    logic [MEMWIDTH-1:0]              pix;
    logic [MEMWIDTH-1:0]              base_q;
    logic [MEMWIDTH-1:0]              map_q;

    logic ser_start;
    logic ser_last;
    logic slot_open;
    logic accept_start;
    logic take_valid;
    logic drop_valid;
    logic fire_ack;

    logic unused_delay;
    assign unused_delay = in_ctrl.delay;

    assign ser_start = !ser_act && slot_full[rd_ptr];
    assign ser_last  = ser_act && (ch == CW'(CORE - 1));
    // A slot whose last word goes out this cycle may be refilled on the same edge.
    assign slot_open = !slot_full[wr_ptr] || (ser_last && (rd_ptr == wr_ptr));

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        accept_start = 1'b0;
        take_valid   = 1'b0;
        drop_valid   = 1'b0;
        fire_ack     = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_ctrl.start) begin
                    accept_start = 1'b1;
                    state_nx     = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (in_ctrl.valid) begin
                    if (slot_open) begin
                        take_valid = 1'b1;
                    end else begin
                        drop_valid = 1'b1;
                    end
                end
                if (in_ctrl.stop) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((slot_full == 2'b00) && !ser_act) begin
                    fire_ack = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Ping-pong slots: free happens before capture so a same-edge refill wins.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            slot_data <= '0;
            slot_full <= 2'b00;
            wr_ptr    <= 1'b0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (ser_last && (rd_ptr == 1'(s))) begin
                    slot_full[s] <= 1'b0;
                end
                if (take_valid && (wr_ptr == 1'(s))) begin
                    slot_full[s] <= 1'b1;
                    slot_data[s] <= in_data;
                end
            end
            if (take_valid) begin
                wr_ptr <= ~wr_ptr;
            end
        end
    end

    // Serializer: channel addresses advance by map_size per word, no multiplier.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ser_act   <= 1'b0;
            ch        <= '0;
            run_addr  <= '0;
            rd_ptr    <= 1'b0;
            pix       <= '0;
            base_q    <= '0;
            map_q     <= '0;
        end else begin
            mem_we <= 1'b0;
            if (ser_start) begin
                mem_we    <= 1'b1;
                mem_addr  <= base_q + pix;
                mem_wdata <= slot_data[rd_ptr][0];
                run_addr  <= base_q + pix + map_q;
                ser_act   <= 1'b1;
                ch        <= CW'(1);
            end else if (ser_act) begin
                mem_we    <= 1'b1;
                mem_addr  <= run_addr;
                mem_wdata <= slot_data[rd_ptr][ch];
                run_addr  <= run_addr + map_q;
                ch        <= ch + CW'(1);
                if (ser_last) begin
                    ser_act <= 1'b0;
                    ch      <= '0;
                    rd_ptr  <= ~rd_ptr;
                    pix     <= pix + MEMWIDTH'(1);
                end
            end
            if (accept_start) begin
                base_q <= _out_base;
                map_q  <= _map_size;
                pix    <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            wb_busy    <= 1'b0;
            wb_ack     <= 1'b0;
            wb_overrun <= 1'b0;
        end else begin
            wb_busy <= (state_nx != S_IDLE);
            wb_ack  <= fire_ack;
            if (accept_start) begin
                wb_overrun <= 1'b0;
            end else if (drop_valid) begin
                wb_overrun <= 1'b1;
            end
        end
    end

endmodule
